// File: rtl/noise_table_loader_if.sv
// Load interface between the table loader, its host word source and the noise_128 generator.
// The loader (master) owns host_ready and the table write port; source/generator (slave) drive the rest.
interface noise_table_loader_if #(
    parameter int LOC_W = 8
);
    logic [63:0]      host_data;
    logic             host_valid;
    logic             host_ready;
    logic [63:0]      mem_data;
    logic [LOC_W-1:0] location;
    logic             load_mem;
    logic             done_wait;

    modport master (
        input  host_data,
        input  host_valid,
        input  done_wait,
        output host_ready,
        output mem_data,
        output location,
        output load_mem
    );

    modport slave (
        output host_data,
        output host_valid,
        output done_wait,
        input  host_ready,
        input  mem_data,
        input  location,
        input  load_mem
    );
endinterface

// File: rtl/noise_table_loader.sv
// Streams DEPTH host words into the noise generator table, then waits for done_wait.
// Reports busy, sticky done/error flags and an XOR checksum of the words accepted in the current load.
module noise_table_loader #(
    parameter int DEPTH   = 128,
    parameter int TIMEOUT = 1024,
    parameter int LOC_W   = 8
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 start,
    input  logic                 abort,
    noise_table_loader_if.master tbl,
    output logic                 busy,
    output logic                 load_done,
    output logic                 load_err,
    output logic [63:0]          checksum
);
    localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [LOC_W-1:0] LAST_INDEX = LOC_W'(DEPTH - 1);
    localparam logic [TW-1:0]    LAST_TICK  = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        WAIT_DONE,
        DONE
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [LOC_W-1:0] index;
    logic [TW-1:0]    timer;
    logic             accept;
    logic             clear_load;
    logic             set_done;
    logic             set_err;
    logic             timer_run;

    assign tbl.host_ready = (state == LOAD);
    assign accept         = tbl.host_ready && tbl.host_valid;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Abort outranks everything; in WAIT_DONE a done_wait in the timeout cycle still counts as success.
    always_comb begin
        state_nx   = state;
        clear_load = 1'b0;
        set_done   = 1'b0;
        set_err    = 1'b0;
        timer_run  = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_nx   = LOAD;
                    clear_load = 1'b1;
                end
            end
            LOAD: begin
                if (abort) begin
                    state_nx = DONE;
                    set_err  = 1'b1;
                end else if (accept && (index == LAST_INDEX)) begin
                    state_nx = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (abort) begin
                    state_nx = DONE;
                    set_err  = 1'b1;
                end else if (tbl.done_wait) begin
                    state_nx = DONE;
                    set_done = 1'b1;
                end else if (timer == LAST_TICK) begin
                    state_nx = DONE;
                    set_err  = 1'b1;
                end else begin
                    timer_run = 1'b1;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            index <= '0;
            timer <= '0;
        end else begin
            if (clear_load) begin
                index <= '0;
            end else if (accept) begin
                index <= index + 1'b1;
            end
            if (clear_load) begin
                timer <= '0;
            end else if (timer_run) begin
                timer <= timer + 1'b1;
            end
        end
    end

    // Each accepted beat becomes a one-cycle table write on the following cycle.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tbl.mem_data <= '0;
            tbl.location <= '0;
            tbl.load_mem <= 1'b0;
            checksum     <= '0;
        end else begin
            tbl.load_mem <= accept;
            if (accept) begin
                tbl.mem_data <= tbl.host_data;
                tbl.location <= index;
            end
            if (clear_load) begin
                checksum <= '0;
            end else if (accept) begin
                checksum <= checksum ^ tbl.host_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            busy      <= 1'b0;
            load_done <= 1'b0;
            load_err  <= 1'b0;
        end else begin
            busy <= (state_nx == LOAD) || (state_nx == WAIT_DONE);
            if (clear_load) begin
                load_done <= 1'b0;
                load_err  <= 1'b0;
            end else begin
                if (set_done) begin
                    load_done <= 1'b1;
                end
                if (set_err) begin
                    load_err <= 1'b1;
                end
            end
        end
    end
endmodule
